// File: rtl/shift_issue_stage_pkg.sv
// Shared constants and decode types for the shift issue stage.
package rv_shift_pkg;

  // Shift codes presented to the barrel shifter's C input.
  localparam logic [4:0] ISLL  = 5'b10001;
  localparam logic [4:0] ISRL  = 5'b10011;
  localparam logic [4:0] ISRA  = 5'b10010;
  localparam logic [4:0] ISNOP = 5'b10000;

  // RV32I major opcodes carrying shifts.
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  // funct3 / funct7 values for the shift group.
  localparam logic [2:0] F3_SL  = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [6:0] F7_0   = 7'b0000000;
  localparam logic [6:0] F7_SRA = 7'b0100000;

  // Result of decoding one instruction into the shift domain.
  typedef struct packed {
    logic       is_shift;
    logic       illegal;
    logic [4:0] code;
  } shift_dec_t;

endpackage

// File: rtl/shift_issue_stage_if.sv
// ID-to-issue handshake and operand bundle.
interface shift_issue_stage_if #(
  parameter int XLEN = 32
);
  logic            valid;
  logic            ready;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] imm;

  // ID side drives the instruction, the stage answers with ready.
  modport master (
    output valid, opcode, funct3, funct7, rs1, rs2, rd, rs1_val, rs2_val, imm,
    input  ready
  );

  modport slave (
    input  valid, opcode, funct3, funct7, rs1, rs2, rd, rs1_val, rs2_val, imm,
    output ready
  );
endinterface

// File: rtl/shift_issue_stage_fwd_mux.sv
// Operand forwarding: x0 is zero, a non-load MEM result beats WB, WB beats the regfile.
module fwd_mux #(
  parameter int XLEN = 32
) (
  input  logic [4:0]      rs,
  input  logic [XLEN-1:0] rf_val,
  input  logic            mem_wen,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_val,
  input  logic            mem_is_load,
  input  logic            wb_wen,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_val,
  output logic [XLEN-1:0] operand
);

  // Pick the youngest available producer of rs.
  always_comb begin
    operand = rf_val;
    if (rs == 5'd0) begin
      operand = '0;
    end else if (mem_wen && !mem_is_load && (mem_rd == rs)) begin
      operand = mem_val;
    end else if (wb_wen && (wb_rd == rs)) begin
      operand = wb_val;
    end
  end

endmodule

// File: rtl/shift_issue_stage.sv
// ID->EX register for the barrel shifter: decodes RV32I shifts, forwards
// operands, inserts load-use bubbles and honours stall/flush.
module shift_issue_stage
  import rv_shift_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  logic               CLK,
  input  logic               RST_X,
  shift_issue_stage_if.slave id,
  input  logic               flush,
  input  logic               ex_stall,
  input  logic               mem_wen,
  input  logic [4:0]         mem_rd,
  input  logic [XLEN-1:0]    mem_val,
  input  logic               mem_is_load,
  input  logic               wb_wen,
  input  logic [4:0]         wb_rd,
  input  logic [XLEN-1:0]    wb_val,
  output logic               ex_valid,
  output logic               ex_is_shift,
  output logic               ex_illegal,
  output logic [4:0]         ex_rd,
  output logic [4:0]         sh_c,
  output logic [XLEN-1:0]    sh_a,
  output logic [SHW-1:0]     sh_b
);

  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic [4:0]      ex_rs1_p1;
  logic [4:0]      ex_rs2_p1;
  logic            ex_breg_p1;
  logic            is_rtype;
  logic            load_use;
  logic            wb_hit_a;
  logic            wb_hit_b;
  logic [SHW-1:0]  b_next;
  shift_dec_t      dec;
  logic            unused_bits;

  fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
    .rs          (id.rs1),
    .rf_val      (id.rs1_val),
    .mem_wen     (mem_wen),
    .mem_rd      (mem_rd),
    .mem_val     (mem_val),
    .mem_is_load (mem_is_load),
    .wb_wen      (wb_wen),
    .wb_rd       (wb_rd),
    .wb_val      (wb_val),
    .operand     (rs1_fwd)
  );

  fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
    .rs          (id.rs2),
    .rf_val      (id.rs2_val),
    .mem_wen     (mem_wen),
    .mem_rd      (mem_rd),
    .mem_val     (mem_val),
    .mem_is_load (mem_is_load),
    .wb_wen      (wb_wen),
    .wb_rd       (wb_rd),
    .wb_val      (wb_val),
    .operand     (rs2_fwd)
  );

  // Only the low SHW bits of the B operand reach the shifter.
  assign unused_bits = ^{rs2_fwd[XLEN-1:SHW], id.imm[XLEN-1:SHW]};

  // rs2 is a real source only for R-type; I-type carries shamt in the immediate.
  assign is_rtype = (id.opcode == OP_R);
  assign b_next   = is_rtype ? rs2_fwd[SHW-1:0] : id.imm[SHW-1:0];

  // A load in MEM cannot forward yet; hold ID for a cycle when it feeds a used source.
  assign load_use = id.valid && mem_is_load && mem_wen && (mem_rd != 5'd0) &&
                    ((mem_rd == id.rs1) || (is_rtype && (mem_rd == id.rs2)));

  // A flush discards the incoming instruction, so ID may always hand it over.
  assign id.ready = flush || (!ex_stall && !load_use);

  // While stalled, a WB write to a held source refreshes the held operand.
  assign wb_hit_a = wb_wen && (wb_rd != 5'd0) && (wb_rd == ex_rs1_p1);
  assign wb_hit_b = wb_wen && (wb_rd != 5'd0) && ex_breg_p1 && (wb_rd == ex_rs2_p1);

  // Decode the shift group; bad funct7 on a shift funct3 is flagged illegal.
  always_comb begin
    dec = '{is_shift: 1'b0, illegal: 1'b0, code: ISNOP};
    if (is_rtype || (id.opcode == OP_I)) begin
      if (id.funct3 == F3_SL) begin
        if (id.funct7 == F7_0) dec = '{is_shift: 1'b1, illegal: 1'b0, code: ISLL};
        else                   dec.illegal = 1'b1;
      end else if (id.funct3 == F3_SR) begin
        if (id.funct7 == F7_0)        dec = '{is_shift: 1'b1, illegal: 1'b0, code: ISRL};
        else if (id.funct7 == F7_SRA) dec = '{is_shift: 1'b1, illegal: 1'b0, code: ISRA};
        else                          dec.illegal = 1'b1;
      end
    end
  end

  // ---- ID -> EX stage boundary ----
  // Priority: flush, then stall (with WB refresh), then bubble, then capture.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      ex_valid    <= 1'b0;
      ex_is_shift <= 1'b0;
      ex_illegal  <= 1'b0;
      ex_rd       <= 5'd0;
      sh_c        <= ISNOP;
      sh_a        <= '0;
      sh_b        <= '0;
      ex_rs1_p1   <= 5'd0;
      ex_rs2_p1   <= 5'd0;
      ex_breg_p1  <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      sh_c     <= ISNOP;
    end else if (ex_stall) begin
      if (wb_hit_a) sh_a <= wb_val;
      if (wb_hit_b) sh_b <= wb_val[SHW-1:0];
    end else if (id.valid && !load_use) begin
      ex_valid    <= 1'b1;
      ex_is_shift <= dec.is_shift;
      ex_illegal  <= dec.illegal;
      ex_rd       <= id.rd;
      sh_c        <= dec.code;
      sh_a        <= rs1_fwd;
      sh_b        <= b_next;
      ex_rs1_p1   <= id.rs1;
      ex_rs2_p1   <= id.rs2;
      ex_breg_p1  <= is_rtype;
    end else begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_issue_stage.sv
// Self-checking bench for shift_issue_stage: vector table, directed
// multi-cycle sequences and a randomized run against a reference model.
module tb_shift_issue_stage;

  localparam logic [4:0] C_SLL = 5'b10001;
  localparam logic [4:0] C_SRL = 5'b10011;
  localparam logic [4:0] C_SRA = 5'b10010;
  localparam logic [4:0] C_NOP = 5'b10000;
  localparam logic [6:0] O_R   = 7'b0110011;
  localparam logic [6:0] O_I   = 7'b0010011;

  logic        CLK;
  logic        RST_X;
  logic        flush;
  logic        ex_stall;
  logic        mem_wen;
  logic [4:0]  mem_rd;
  logic [31:0] mem_val;
  logic        mem_is_load;
  logic        wb_wen;
  logic [4:0]  wb_rd;
  logic [31:0] wb_val;
  logic        ex_valid;
  logic        ex_is_shift;
  logic        ex_illegal;
  logic [4:0]  ex_rd;
  logic [4:0]  sh_c;
  logic [31:0] sh_a;
  logic [4:0]  sh_b;

  shift_issue_stage_if id_if ();

  shift_issue_stage dut (
    .CLK         (CLK),
    .RST_X       (RST_X),
    .id          (id_if),
    .flush       (flush),
    .ex_stall    (ex_stall),
    .mem_wen     (mem_wen),
    .mem_rd      (mem_rd),
    .mem_val     (mem_val),
    .mem_is_load (mem_is_load),
    .wb_wen      (wb_wen),
    .wb_rd       (wb_rd),
    .wb_val      (wb_val),
    .ex_valid    (ex_valid),
    .ex_is_shift (ex_is_shift),
    .ex_illegal  (ex_illegal),
    .ex_rd       (ex_rd),
    .sh_c        (sh_c),
    .sh_a        (sh_a),
    .sh_b        (sh_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  // Architectural view of the EX register plus the source indices it was built from.
  typedef struct packed {
    logic        valid;
    logic        is_shift;
    logic        illegal;
    logic [4:0]  rd;
    logic [4:0]  c;
    logic [4:0]  b;
    logic [31:0] a;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        breg;
  } mst_t;

  mst_t m;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] v1, v2, imm;
    logic        mw;
    logic [4:0]  mrd;
    logic [31:0] mv;
    logic        ml;
    logic        ww;
    logic [4:0]  wrd;
    logic [31:0] wv;
    logic [4:0]  ec;
    logic [31:0] ea;
    logic [4:0]  eb;
    logic        esh, eill;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic mst_t rst_state();
    mst_t s = '0;
    s.c = C_NOP;
    return s;
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 5'd0) return 32'd0;
    if (mem_wen && !mem_is_load && mem_rd == rs) return mem_val;
    if (wb_wen && wb_rd == rs) return wb_val;
    return rf;
  endfunction

  // Returns {illegal, is_shift, code}.
  function automatic logic [6:0] ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                            input logic [6:0] f7);
    if (op != O_R && op != O_I) return {2'b00, C_NOP};
    case ({f3, f7})
      {3'b001, 7'b0000000}: return {2'b01, C_SLL};
      {3'b101, 7'b0000000}: return {2'b01, C_SRL};
      {3'b101, 7'b0100000}: return {2'b01, C_SRA};
      default: return {(f3 == 3'b001 || f3 == 3'b101), 1'b0, C_NOP};
    endcase
  endfunction

  function automatic logic ref_load_use();
    return id_if.valid && mem_is_load && mem_wen && (mem_rd != 5'd0) &&
           (mem_rd == id_if.rs1 || (id_if.opcode == O_R && mem_rd == id_if.rs2));
  endfunction

  function automatic logic ref_ready();
    return flush || (!ex_stall && !ref_load_use());
  endfunction

  function automatic mst_t ref_next(input mst_t s);
    mst_t        n = s;
    logic [6:0]  d;
    logic [31:0] t;
    if (flush) begin
      n.valid = 1'b0;
      n.c     = C_NOP;
    end else if (ex_stall) begin
      if (wb_wen && wb_rd != 5'd0 && wb_rd == s.rs1) n.a = wb_val;
      if (wb_wen && wb_rd != 5'd0 && s.breg && wb_rd == s.rs2) n.b = wb_val[4:0];
    end else if (id_if.valid && !ref_load_use()) begin
      d          = ref_decode(id_if.opcode, id_if.funct3, id_if.funct7);
      n.valid    = 1'b1;
      n.illegal  = d[6];
      n.is_shift = d[5];
      n.c        = d[4:0];
      n.rd       = id_if.rd;
      n.rs1      = id_if.rs1;
      n.rs2      = id_if.rs2;
      n.breg     = (id_if.opcode == O_R);
      n.a        = ref_fwd(id_if.rs1, id_if.rs1_val);
      t          = n.breg ? ref_fwd(id_if.rs2, id_if.rs2_val) : id_if.imm;
      n.b        = t[4:0];
    end else begin
      n.valid = 1'b0;
    end
    return n;
  endfunction

  task automatic check_outs();
    chk("ex_valid",    32'(ex_valid),    32'(m.valid));
    chk("ex_is_shift", 32'(ex_is_shift), 32'(m.is_shift));
    chk("ex_illegal",  32'(ex_illegal),  32'(m.illegal));
    chk("ex_rd",       32'(ex_rd),       32'(m.rd));
    chk("sh_c",        32'(sh_c),        32'(m.c));
    chk("sh_a",        sh_a,             m.a);
    chk("sh_b",        32'(sh_b),        32'(m.b));
  endtask

  // One clock: check ready against the model, advance, check all outputs.
  task automatic cycle();
    mst_t n;
    #1;
    chk("id_ready", 32'(id_if.ready), 32'(ref_ready()));
    n = ref_next(m);
    @(posedge CLK);
    m = n;
    #1;
    check_outs();
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm);
    id_if.opcode  = op;
    id_if.funct3  = f3;
    id_if.funct7  = f7;
    id_if.rs1     = rs1;
    id_if.rs2     = rs2;
    id_if.rd      = rd;
    id_if.rs1_val = v1;
    id_if.rs2_val = v2;
    id_if.imm     = imm;
  endtask

  task automatic set_fwd(input logic mw, input logic [4:0] mrd, input logic [31:0] mv,
                         input logic ml, input logic ww, input logic [4:0] wrd,
                         input logic [31:0] wv);
    mem_wen     = mw;
    mem_rd      = mrd;
    mem_val     = mv;
    mem_is_load = ml;
    wb_wen      = ww;
    wb_rd       = wrd;
    wb_val      = wv;
  endtask

  initial begin
    vt[0] = '{O_I, 3'd5, 7'h20, 5'd6, 5'd4, 5'd5, 32'h8000_0000, 32'd0, 32'h404,
              1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0,
              C_SRA, 32'h8000_0000, 5'd4, 1'b1, 1'b0};
    vt[1] = '{O_R, 3'd1, 7'h00, 5'd1, 5'd2, 5'd3, 32'h1234, 32'd3, 32'd0,
              1'b1, 5'd2, 32'h25, 1'b0, 1'b1, 5'd2, 32'd7,
              C_SLL, 32'h1234, 5'd5, 1'b1, 1'b0};
    vt[2] = '{O_I, 3'd5, 7'h21, 5'd7, 5'd3, 5'd8, 32'hAA, 32'd0, 32'h423,
              1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0,
              C_NOP, 32'hAA, 5'd3, 1'b0, 1'b1};
    vt[3] = '{O_R, 3'd5, 7'h00, 5'd9, 5'd10, 5'd11, 32'h1111, 32'h3F, 32'd0,
              1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd9, 32'hDEAD_0000,
              C_SRL, 32'hDEAD_0000, 5'h1F, 1'b1, 1'b0};
    vt[4] = '{O_R, 3'd1, 7'h00, 5'd0, 5'd0, 5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,
              1'b1, 5'd0, 32'h99, 1'b0, 1'b1, 5'd0, 32'h55,
              C_SLL, 32'd0, 5'd0, 1'b1, 1'b0};
    vt[5] = '{O_I, 3'd0, 7'h03, 5'd4, 5'd7, 5'd13, 32'h42, 32'd0, 32'h067,
              1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0,
              C_NOP, 32'h42, 5'd7, 1'b0, 1'b0};
    vt[6] = '{O_R, 3'd1, 7'h01, 5'd3, 5'd4, 5'd14, 32'd1, 32'd2, 32'd0,
              1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0,
              C_NOP, 32'd1, 5'd2, 1'b0, 1'b1};
    vt[7] = '{O_I, 3'd1, 7'h00, 5'd5, 5'd8, 5'd15, 32'h77, 32'd0, 32'h008,
              1'b1, 5'd8, 32'h123, 1'b1, 1'b0, 5'd0, 32'd0,
              C_SLL, 32'h77, 5'd8, 1'b1, 1'b0};
    vt[8] = '{O_R, 3'd5, 7'h20, 5'd2, 5'd3, 5'd16, 32'hF0F0_F0F0, 32'hFFFF_FFE1, 32'd0,
              1'b1, 5'd3, 32'h40, 1'b0, 1'b1, 5'd2, 32'h13,
              C_SRA, 32'h13, 5'd0, 1'b1, 1'b0};

    // Power-up reset.
    RST_X       = 1'b1;
    flush       = 1'b0;
    ex_stall    = 1'b0;
    id_if.valid = 1'b0;
    set_instr(7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    #1 RST_X = 1'b0;
    m = rst_state();
    #2;
    check_outs();
    @(posedge CLK);
    @(posedge CLK);
    #3 RST_X = 1'b1;
    cycle();

    // Single-instruction vectors.
    for (int i = 0; i < 9; i++) begin
      set_instr(vt[i].op, vt[i].f3, vt[i].f7, vt[i].rs1, vt[i].rs2, vt[i].rd,
                vt[i].v1, vt[i].v2, vt[i].imm);
      set_fwd(vt[i].mw, vt[i].mrd, vt[i].mv, vt[i].ml, vt[i].ww, vt[i].wrd, vt[i].wv);
      id_if.valid = 1'b1;
      cycle();
      chk($sformatf("vec%0d_valid", i), 32'(ex_valid), 32'd1);
      chk($sformatf("vec%0d_sh_c", i), 32'(sh_c), 32'(vt[i].ec));
      chk($sformatf("vec%0d_sh_a", i), sh_a, vt[i].ea);
      chk($sformatf("vec%0d_sh_b", i), 32'(sh_b), 32'(vt[i].eb));
      chk($sformatf("vec%0d_rd", i), 32'(ex_rd), 32'(vt[i].rd));
      chk($sformatf("vec%0d_shift", i), 32'(ex_is_shift), 32'(vt[i].esh));
      chk($sformatf("vec%0d_illegal", i), 32'(ex_illegal), 32'(vt[i].eill));
    end

    // Load in MEM feeding srl rs1: one bubble, then WB supplies the loaded value.
    set_instr(O_R, 3'd5, 7'h00, 5'd1, 5'd2, 5'd6, 32'h111, 32'd3, 32'd0);
    set_fwd(1'b1, 5'd1, 32'hAAAA, 1'b1, 1'b0, 5'd0, 32'd0);
    id_if.valid = 1'b1;
    #1 chk("lu_ready", 32'(id_if.ready), 32'd0);
    cycle();
    chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd1, 32'hCAFE_F00D);
    cycle();
    chk("lu_after_valid", 32'(ex_valid), 32'd1);
    chk("lu_after_sh_a", sh_a, 32'hCAFE_F00D);
    chk("lu_after_sh_c", 32'(sh_c), 32'(C_SRL));
    chk("lu_after_sh_b", 32'(sh_b), 32'd3);

    // Three stalled cycles; WB rewrites rs1 then rs2 of the held instruction.
    ex_stall = 1'b1;
    set_instr(O_R, 3'd1, 7'h00, 5'd4, 5'd5, 5'd7, 32'h5, 32'h6, 32'd0);
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd1, 32'h0BAD_BEEF);
      if (k == 2) set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd2, 32'h1D);
      #1 chk("stall_ready", 32'(id_if.ready), 32'd0);
      cycle();
      chk("stall_valid", 32'(ex_valid), 32'd1);
      chk("stall_sh_c", 32'(sh_c), 32'(C_SRL));
      chk("stall_rd", 32'(ex_rd), 32'd6);
      chk("stall_sh_a", sh_a, (k == 0) ? 32'hCAFE_F00D : 32'h0BAD_BEEF);
      chk("stall_sh_b", 32'(sh_b), (k < 2) ? 32'd3 : 32'h1D);
    end

    // Flush wins over stall and discards the incoming instruction.
    flush = 1'b1;
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    #1 chk("flush_ready", 32'(id_if.ready), 32'd1);
    cycle();
    chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_sh_c", 32'(sh_c), 32'(C_NOP));
    flush    = 1'b0;
    ex_stall = 1'b0;

    // No instruction offered and no stall: bubble.
    id_if.valid = 1'b0;
    cycle();
    chk("idle_valid", 32'(ex_valid), 32'd0);

    // Capture, then asynchronous reset in mid-cycle.
    id_if.valid = 1'b1;
    set_instr(O_R, 3'd1, 7'h00, 5'd3, 5'd3, 5'd9, 32'h0F, 32'h0F, 32'd0);
    cycle();
    chk("pre_rst_valid", 32'(ex_valid), 32'd1);
    #2 RST_X = 1'b0;
    #1;
    m = rst_state();
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_sh_c", 32'(sh_c), 32'(C_NOP));
    chk("rst_sh_a", sh_a, 32'd0);
    chk("rst_sh_b", 32'(sh_b), 32'd0);
    chk("rst_rd", 32'(ex_rd), 32'd0);
    @(posedge CLK);
    #3 RST_X = 1'b1;
    check_outs();
    cycle();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      int r;
      flush       = ($urandom_range(9) == 0);
      ex_stall    = ($urandom_range(3) == 0);
      id_if.valid = ($urandom_range(9) < 7);
      r = $urandom_range(4);
      id_if.opcode = (r < 2) ? O_R : (r < 4) ? O_I : 7'($urandom);
      r = $urandom_range(2);
      id_if.funct3 = (r == 0) ? 3'd1 : (r == 1) ? 3'd5 : 3'($urandom);
      r = $urandom_range(2);
      id_if.funct7 = (r == 0) ? 7'h00 : (r == 1) ? 7'h20 : 7'($urandom);
      id_if.rs1     = 5'($urandom_range(3));
      id_if.rs2     = 5'($urandom_range(3));
      id_if.rd      = 5'($urandom);
      id_if.rs1_val = $urandom;
      id_if.rs2_val = $urandom;
      id_if.imm     = $urandom;
      set_fwd(1'($urandom), 5'($urandom_range(3)), $urandom, ($urandom_range(2) == 0),
              1'($urandom), 5'($urandom_range(3)), $urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
